// File: rtl/ads8686_conv_sequencer_pkg.sv
// Shared ADS8686 sequencer definitions: FSM state encoding, SPI frame width and channel
// field positions, also used by the SPI master and the host register map.
package ads8686_conv_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CONVST   = 3'd1,
      ST_WAIT_HI  = 3'd2,
      ST_WAIT_LO  = 3'd3,
      ST_SPI_GO   = 3'd4,
      ST_SPI_WAIT = 3'd5,
      ST_WRITE    = 3'd6
   } seq_state_e;

   localparam int unsigned SPI_FRAME_W = 32;
   localparam int unsigned CHA_MSB     = 31;
   localparam int unsigned CHA_LSB     = 16;
   localparam int unsigned CHB_MSB     = 15;
   localparam int unsigned CHB_LSB     = 0;

endpackage

// File: rtl/ads8686_conv_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous status pin (ADS8686 BUSY and similar).
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ads8686_conv_sequencer.sv
// ADS8686 conversion sequencer: CONVST pulse, BUSY handshake, one SPI frame read,
// FIFO write of {chA,chB}, plus sticky status flags and a written-sample counter.
module ads8686_conv_sequencer
   import ads8686_conv_sequencer_pkg::*;
#(
   parameter int unsigned CONV_PERIOD  = 1000,
   parameter int unsigned CONVST_WIDTH = 4,
   parameter int unsigned BUSY_TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   single_shot,
   input  logic                   busy,
   output logic                   convst,
   output logic                   spi_start,
   input  logic                   spi_done,
   input  logic [SPI_FRAME_W-1:0] spi_rdata,
   input  logic                   fifo_full,
   output logic                   fifo_wr_en,
   output logic [SPI_FRAME_W-1:0] fifo_din,
   input  logic                   clr_status,
   output logic                   overflow,
   output logic                   overrun,
   output logic                   timeout,
   output logic [31:0]            sample_count
);

   localparam int unsigned PER_W    = $clog2(CONV_PERIOD);
   localparam int unsigned WAIT_MAX = (CONVST_WIDTH > BUSY_TIMEOUT) ? CONVST_WIDTH : BUSY_TIMEOUT;
   localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

   seq_state_e        state;
   logic [PER_W-1:0]  per_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              busy_s;
   logic              tick;
   logic              start_req;

   sync_2ff u_busy_sync (
      .clk (clk),
      .rst (rst),
      .d   (busy),
      .q   (busy_s)
   );

   always_comb begin
      tick      = enable && (per_cnt == PER_W'(CONV_PERIOD - 1));
      start_req = (tick || single_shot) && (state == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_cnt <= '0;
      end else if (!enable || per_cnt == PER_W'(CONV_PERIOD - 1)) begin
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         convst       <= 1'b0;
         spi_start    <= 1'b0;
         fifo_wr_en   <= 1'b0;
         fifo_din     <= '0;
         overflow     <= 1'b0;
         overrun      <= 1'b0;
         timeout      <= 1'b0;
         sample_count <= '0;
      end else begin
         spi_start  <= 1'b0;
         fifo_wr_en <= 1'b0;
         // Clear first so a same-cycle set event below takes precedence.
         if (clr_status) begin
            overflow     <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
            sample_count <= '0;
         end
         if (tick && state != ST_IDLE) overrun <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (start_req) begin
                  state    <= ST_CONVST;
                  convst   <= 1'b1;
                  wait_cnt <= '0;
               end
            end
            ST_CONVST: begin
               if (wait_cnt == WAIT_W'(CONVST_WIDTH - 1)) begin
                  convst   <= 1'b0;
                  state    <= ST_WAIT_HI;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_WAIT_HI, ST_WAIT_LO: begin
               if ((state == ST_WAIT_HI) ? busy_s : !busy_s) begin
                  state     <= (state == ST_WAIT_HI) ? ST_WAIT_LO : ST_SPI_GO;
                  spi_start <= (state == ST_WAIT_LO);
                  wait_cnt  <= '0;
               end else if (wait_cnt == WAIT_W'(BUSY_TIMEOUT - 1)) begin
                  timeout <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_SPI_GO: begin
               state <= ST_SPI_WAIT;
            end
            ST_SPI_WAIT: begin
               // Write decision is taken on the spi_done cycle so the strobe lands in WRITE.
               if (spi_done) begin
                  fifo_din <= spi_rdata;
                  state    <= ST_WRITE;
                  if (!fifo_full) begin
                     fifo_wr_en   <= 1'b1;
                     sample_count <= (clr_status ? 32'd0 : sample_count) + 32'd1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               state <= ST_IDLE;
            end
            default: begin
               state  <= ST_IDLE;
               convst <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ads8686_conv_sequencer.sv
// Directed bench for ads8686_conv_sequencer: two instances (period 100 and 30) with
// behavioural BUSY and SPI-master models.
module tb_ads8686_conv_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic enable      [2];
   logic single_shot [2];
   logic fifo_full   [2];
   logic clr_status  [2];
   logic busy_dis    [2];
   int unsigned cyc = 0;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned PER = (g == 0) ? 100 : 30;
      logic        busy = 1'b0;
      logic        convst, spi_start, fifo_wr_en, overflow, overrun, timeout;
      logic        spi_done = 1'b0;
      logic [31:0] spi_rdata = 32'h1234ABCD;
      logic [31:0] fifo_din, sample_count;

      int          bcnt = 0;
      int          scnt = 0;
      logic        mcq  = 1'b0;
      int unsigned wr_cnt = 0, start_cnt = 0, rise_cnt = 0, run = 0, last_len = 0;
      int unsigned gap = 0, last_wr = 0;
      logic [31:0] last_din = '0;
      logic        cq = 1'b0;

      // BUSY: rises 3 clk after convst rises, stays high 20 clk (unless disabled)
      always @(posedge clk) begin
         mcq <= convst;
         if (convst && !mcq) bcnt <= 1;
         else if (bcnt != 0 && bcnt < 40) bcnt <= bcnt + 1;
         else bcnt <= 0;
         busy <= !busy_dis[g] && bcnt >= 2 && bcnt < 22;
      end

      // SPI master: spi_done 10 clk after spi_start; not affected by sequencer reset
      always @(posedge clk) begin
         if (spi_start) begin
            scnt     <= 10;
            spi_done <= 1'b0;
         end else if (scnt != 0) begin
            scnt     <= scnt - 1;
            spi_done <= (scnt == 1);
         end else begin
            spi_done <= 1'b0;
         end
      end

      always @(posedge clk) begin
         cq <= convst;
         if (convst && !cq) rise_cnt <= rise_cnt + 1;
         if (convst) run <= run + 1;
         else if (run != 0) begin
            last_len <= run;
            run      <= 0;
         end
         if (spi_start) start_cnt <= start_cnt + 1;
         if (fifo_wr_en) begin
            wr_cnt   <= wr_cnt + 1;
            last_din <= fifo_din;
            gap      <= cyc - last_wr;
            last_wr  <= cyc;
         end
      end

      ads8686_conv_sequencer #(
         .CONV_PERIOD  (PER),
         .CONVST_WIDTH (4),
         .BUSY_TIMEOUT (50)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .enable       (enable[g]),
         .single_shot  (single_shot[g]),
         .busy         (busy),
         .convst       (convst),
         .spi_start    (spi_start),
         .spi_done     (spi_done),
         .spi_rdata    (spi_rdata),
         .fifo_full    (fifo_full[g]),
         .fifo_wr_en   (fifo_wr_en),
         .fifo_din     (fifo_din),
         .clr_status   (clr_status[g]),
         .overflow     (overflow),
         .overrun      (overrun),
         .timeout      (timeout),
         .sample_count (sample_count)
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_wr0(input int unsigned target, input int lim, input string tag);
      int n = 0;
      while (g_inst[0].wr_cnt < target && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(g_inst[0].wr_cnt >= target), 32'd1);
   endtask

   task automatic pulse_ss0();
      single_shot[0] = 1'b1;
      @(negedge clk);
      single_shot[0] = 1'b0;
   endtask

   int unsigned b_wr, b_st, b_rise;

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         enable[i] = 0; single_shot[i] = 0; fifo_full[i] = 0; clr_status[i] = 0; busy_dis[i] = 0;
      end
      repeat (3) @(negedge clk);
      chk("rst_convst",    32'(g_inst[0].convst),     0);
      chk("rst_spi_start", 32'(g_inst[0].spi_start),  0);
      chk("rst_wr_en",     32'(g_inst[0].fifo_wr_en), 0);
      chk("rst_din",       g_inst[0].fifo_din,        0);
      chk("rst_count",     g_inst[0].sample_count,    0);
      chk("rst_flags",     {29'd0, g_inst[0].overflow, g_inst[0].overrun, g_inst[0].timeout}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: single shot
      b_wr = g_inst[0].wr_cnt; b_st = g_inst[0].start_cnt;
      pulse_ss0();
      chk("t1_convst_lat1", 32'(g_inst[0].convst), 1);
      repeat (3) @(negedge clk);
      chk("t1_convst_j3", 32'(g_inst[0].convst), 1);
      @(negedge clk);
      chk("t1_convst_j4", 32'(g_inst[0].convst), 0);
      wait_wr0(b_wr + 1, 100, "t1_wr_wait");
      repeat (5) @(negedge clk);
      chk("t1_convst_len", g_inst[0].last_len, 4);
      chk("t1_starts",     g_inst[0].start_cnt - b_st, 1);
      chk("t1_writes",     g_inst[0].wr_cnt - b_wr, 1);
      chk("t1_wdata",      g_inst[0].last_din, 32'h1234ABCD);
      chk("t1_count",      g_inst[0].sample_count, 1);

      // 2: continuous, period 100
      b_wr = g_inst[0].wr_cnt;
      enable[0] = 1'b1;
      repeat (1000) @(negedge clk);
      enable[0] = 1'b0;
      repeat (150) @(negedge clk);
      chk("t2_writes",  g_inst[0].wr_cnt - b_wr, 10);
      chk("t2_gap",     g_inst[0].gap, 100);
      chk("t2_overrun", 32'(g_inst[0].overrun), 0);
      chk("t2_count",   g_inst[0].sample_count, 11);

      // 3: period 30 shorter than a conversion
      b_rise = g_inst[1].rise_cnt; b_wr = g_inst[1].wr_cnt;
      enable[1] = 1'b1;
      repeat (300) @(negedge clk);
      enable[1] = 1'b0;
      repeat (100) @(negedge clk);
      chk("t3_overrun", 32'(g_inst[1].overrun), 1);
      chk("t3_convst",  g_inst[1].rise_cnt - b_rise, 5);
      chk("t3_writes",  g_inst[1].wr_cnt - b_wr, 5);
      chk("t3_count",   g_inst[1].sample_count, 5);

      // 4: BUSY never rises
      busy_dis[0] = 1'b1;
      b_wr = g_inst[0].wr_cnt; b_st = g_inst[0].start_cnt;
      pulse_ss0();
      repeat (53) @(negedge clk);
      chk("t4_timeout_j53", 32'(g_inst[0].timeout), 0);
      @(negedge clk);
      chk("t4_timeout_j54", 32'(g_inst[0].timeout), 1);
      repeat (60) @(negedge clk);
      chk("t4_no_start", g_inst[0].start_cnt - b_st, 0);
      chk("t4_no_write", g_inst[0].wr_cnt - b_wr, 0);
      busy_dis[0] = 1'b0;
      repeat (5) @(negedge clk);
      pulse_ss0();
      wait_wr0(b_wr + 1, 100, "t4_recover_wait");
      @(negedge clk);
      chk("t4_recover_count", g_inst[0].sample_count, 12);
      chk("t4_timeout_sticky", 32'(g_inst[0].timeout), 1);

      // 5: FIFO full, then clear, then clear colliding with a write
      repeat (5) @(negedge clk);
      fifo_full[0] = 1'b1;
      b_wr = g_inst[0].wr_cnt;
      pulse_ss0();
      repeat (60) @(negedge clk);
      fifo_full[0] = 1'b0;
      chk("t5_no_write", g_inst[0].wr_cnt - b_wr, 0);
      chk("t5_overflow", 32'(g_inst[0].overflow), 1);
      chk("t5_count",    g_inst[0].sample_count, 12);
      clr_status[0] = 1'b1;
      @(negedge clk);
      clr_status[0] = 1'b0;
      chk("t5_clr_overflow", 32'(g_inst[0].overflow), 0);
      chk("t5_clr_timeout",  32'(g_inst[0].timeout), 0);
      chk("t5_clr_count",    g_inst[0].sample_count, 0);
      repeat (5) @(negedge clk);
      pulse_ss0();
      repeat (37) @(negedge clk);
      clr_status[0] = 1'b1;
      @(negedge clk);
      clr_status[0] = 1'b0;
      chk("t5_collide_wr_en", 32'(g_inst[0].fifo_wr_en), 1);
      chk("t5_collide_count", g_inst[0].sample_count, 1);

      // 6: reset during SPI_WAIT, late spi_done ignored
      repeat (10) @(negedge clk);
      b_wr = g_inst[0].wr_cnt;
      pulse_ss0();
      repeat (30) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_rst_convst",    32'(g_inst[0].convst),     0);
      chk("t6_rst_spi_start", 32'(g_inst[0].spi_start),  0);
      chk("t6_rst_wr_en",     32'(g_inst[0].fifo_wr_en), 0);
      chk("t6_rst_count",     g_inst[0].sample_count,    0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("t6_late_done_ignored", g_inst[0].wr_cnt - b_wr, 0);
      chk("t6_din_cleared",       g_inst[0].fifo_din, 0);
      // reset while convst is high drops it immediately
      pulse_ss0();
      chk("t6_convst_before", 32'(g_inst[0].convst), 1);
      rst = 1'b1;
      #1;
      chk("t6_convst_abort", 32'(g_inst[0].convst), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      b_wr = g_inst[0].wr_cnt;
      pulse_ss0();
      wait_wr0(b_wr + 1, 100, "t6_final_wait");
      @(negedge clk);
      chk("t6_final_data",  g_inst[0].last_din, 32'h1234ABCD);
      chk("t6_final_count", g_inst[0].sample_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
